// File: rtl/rename_stage_if.sv
// Rename-stage handshake bundle: decoded instruction in, renamed instruction
// out, plus the busy-list write port and the commit/flush side channel.
interface rename_stage_if #(parameter int LOG_PHYS = 6);
  logic                Valid_IN;
  logic [4:0]          SrcA_IN;
  logic [4:0]          SrcB_IN;
  logic [4:0]          Dest_IN;
  logic                WritesDest_IN;
  logic                Stall_IN;
  logic                Stall_OUT;
  logic                Valid_OUT;
  logic [LOG_PHYS-1:0] PhysSrcA_OUT;
  logic [LOG_PHYS-1:0] PhysSrcB_OUT;
  logic [LOG_PHYS-1:0] PhysDest_OUT;
  logic [LOG_PHYS-1:0] PrevPhysDest_OUT;
  logic [LOG_PHYS-1:0] BusyReg_OUT;
  logic                SetBusy_OUT;
  logic                BusyValue_OUT;
  logic                Commit_IN;
  logic [4:0]          CommitArch_IN;
  logic [LOG_PHYS-1:0] CommitPhys_IN;
  logic [LOG_PHYS-1:0] CommitPrevPhys_IN;
  logic                Flush_IN;

  modport slave (
    input  Valid_IN, SrcA_IN, SrcB_IN, Dest_IN, WritesDest_IN, Stall_IN,
    input  Commit_IN, CommitArch_IN, CommitPhys_IN, CommitPrevPhys_IN, Flush_IN,
    output Stall_OUT, Valid_OUT, PhysSrcA_OUT, PhysSrcB_OUT, PhysDest_OUT,
    output PrevPhysDest_OUT, BusyReg_OUT, SetBusy_OUT, BusyValue_OUT
  );

  modport master (
    output Valid_IN, SrcA_IN, SrcB_IN, Dest_IN, WritesDest_IN, Stall_IN,
    output Commit_IN, CommitArch_IN, CommitPhys_IN, CommitPrevPhys_IN, Flush_IN,
    input  Stall_OUT, Valid_OUT, PhysSrcA_OUT, PhysSrcB_OUT, PhysDest_OUT,
    input  PrevPhysDest_OUT, BusyReg_OUT, SetBusy_OUT, BusyValue_OUT
  );
endinterface

// File: rtl/rename_stage.sv
// Register rename: speculative and retirement maps plus a circular free list
// whose speculative head snaps back to the commit head on flush.
module rename_stage #(
  parameter int NUM_PHYS_REGS = 64,
  parameter int NUM_ARCH_REGS = 32,
  localparam int LOG_PHYS = $clog2(NUM_PHYS_REGS),
  localparam int FL_DEPTH = NUM_PHYS_REGS - NUM_ARCH_REGS,
  localparam int LOG_FL   = $clog2(FL_DEPTH)
) (
  input logic          CLK,
  input logic          RESET,
  rename_stage_if.slave bus
);

  logic [LOG_PHYS-1:0] specMap   [NUM_ARCH_REGS];
  logic [LOG_PHYS-1:0] retireMap [NUM_ARCH_REGS];
  logic [LOG_PHYS-1:0] freeList  [FL_DEPTH];
  logic [LOG_FL:0]     head, commitHead, tail;
  logic [LOG_FL:0]     freeCount;
  logic                effDest, fire, commitHit;
  logic [LOG_PHYS-1:0] allocPhys;

  logic                validQ, setBusyQ;
  logic [LOG_PHYS-1:0] physSrcAQ, physSrcBQ, physDestQ, prevPhysDestQ;

  assign freeCount = tail - head;
  assign effDest   = bus.WritesDest_IN && (bus.Dest_IN != 5'd0);
  assign allocPhys = freeList[head[LOG_FL-1:0]];

  // Registered count only: a commit this cycle frees a slot next cycle.
  assign bus.Stall_OUT = bus.Stall_IN | (bus.Valid_IN & effDest & (freeCount == '0));
  assign fire          = bus.Valid_IN & ~bus.Stall_OUT & ~bus.Flush_IN;

  // Arch $0 stays hard-wired to phys 0 in both maps.
  assign commitHit = bus.Commit_IN && (bus.CommitArch_IN != 5'd0);

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      for (int i = 0; i < NUM_ARCH_REGS; i++) begin
        specMap[i]   <= LOG_PHYS'(i);
        retireMap[i] <= LOG_PHYS'(i);
      end
      for (int k = 0; k < FL_DEPTH; k++)
        freeList[k] <= LOG_PHYS'(NUM_ARCH_REGS + k);
      head          <= '0;
      commitHead    <= '0;
      tail          <= (LOG_FL+1)'(FL_DEPTH);
      validQ        <= 1'b0;
      setBusyQ      <= 1'b0;
      physSrcAQ     <= '0;
      physSrcBQ     <= '0;
      physDestQ     <= '0;
      prevPhysDestQ <= '0;
    end else begin
      if (bus.Commit_IN) begin
        if (commitHit)
          retireMap[bus.CommitArch_IN] <= bus.CommitPhys_IN;
        freeList[tail[LOG_FL-1:0]] <= bus.CommitPrevPhys_IN;
        tail       <= tail + 1'b1;
        commitHead <= commitHead + 1'b1;
      end

      if (bus.Flush_IN) begin
        // Restore includes the commit landing on this same edge.
        for (int i = 0; i < NUM_ARCH_REGS; i++)
          specMap[i] <= (commitHit && (bus.CommitArch_IN == 5'(i))) ?
                        bus.CommitPhys_IN : retireMap[i];
        head     <= commitHead + (LOG_FL+1)'(bus.Commit_IN);
        validQ   <= 1'b0;
        setBusyQ <= 1'b0;
      end else if (fire) begin
        validQ    <= 1'b1;
        physSrcAQ <= specMap[bus.SrcA_IN];
        physSrcBQ <= specMap[bus.SrcB_IN];
        if (effDest) begin
          specMap[bus.Dest_IN] <= allocPhys;
          head                 <= head + 1'b1;
          physDestQ            <= allocPhys;
          prevPhysDestQ        <= specMap[bus.Dest_IN];
          setBusyQ             <= 1'b1;
        end else begin
          physDestQ     <= '0;
          prevPhysDestQ <= '0;
          setBusyQ      <= 1'b0;
        end
      end else begin
        setBusyQ <= 1'b0;
        if (!bus.Stall_IN)
          validQ <= 1'b0;
      end
    end
  end

  assign bus.Valid_OUT        = validQ;
  assign bus.PhysSrcA_OUT     = physSrcAQ;
  assign bus.PhysSrcB_OUT     = physSrcBQ;
  assign bus.PhysDest_OUT     = physDestQ;
  assign bus.PrevPhysDest_OUT = prevPhysDestQ;
  assign bus.BusyReg_OUT      = physDestQ;
  assign bus.SetBusy_OUT      = setBusyQ;
  assign bus.BusyValue_OUT    = setBusyQ;

endmodule

// File: tb/tb_rename_stage.sv
// Scoreboard bench for rename_stage: a queue-based rename model predicts each
// renamed instruction; a negedge monitor compares whatever the DUT presents.
module tb_rename_stage;

  typedef struct {int a; int b; int d; int p; bit busy;} expT;
  typedef struct {int arch; int phys; int prev;} robT;

  logic clk = 1'b0;
  logic rstN = 1'b0;
  always #5 clk = ~clk;

  rename_stage_if #(.LOG_PHYS(6)) bus();

  rename_stage dut (.CLK(clk), .RESET(rstN), .bus(bus));

  int checks = 0;
  int failures = 0;

  // Reference model: the free list is the queue of entries from the commit
  // point onwards; spec counts how many of those are speculatively handed out.
  int  specMapM [32];
  int  retMapM  [32];
  int  flq [$];
  int  spec;
  robT rob [$];
  expT sb [$];
  bit  monOn = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < 32; i++) begin
      specMapM[i] = i;
      retMapM[i]  = i;
    end
    flq.delete();
    for (int k = 0; k < 32; k++) flq.push_back(32 + k);
    spec = 0;
    rob.delete();
  endtask

  task automatic idleInputs();
    bus.Valid_IN = 0; bus.SrcA_IN = 0; bus.SrcB_IN = 0; bus.Dest_IN = 0;
    bus.WritesDest_IN = 0; bus.Stall_IN = 0; bus.Commit_IN = 0;
    bus.CommitArch_IN = 0; bus.CommitPhys_IN = 0; bus.CommitPrevPhys_IN = 0;
    bus.Flush_IN = 0;
  endtask

  task automatic doReset();
    @(posedge clk); #1;
    rstN = 1'b0;
    idleInputs();
    modelReset();
  endtask

  task automatic cycle(input bit v, input int a, input int b, input int d, input bit wd,
                       input bit stallIn, input bit doCommit, input bit flush);
    robT c;
    expT e;
    bit cm, eff, stallExp, fire;
    int freeCnt;
    @(posedge clk); #1;
    rstN = 1'b1;
    cm = doCommit && (rob.size() > 0);
    c = '{0, 0, 0};
    if (cm) c = rob[0];
    bus.Valid_IN = v; bus.SrcA_IN = 5'(a); bus.SrcB_IN = 5'(b); bus.Dest_IN = 5'(d);
    bus.WritesDest_IN = wd; bus.Stall_IN = stallIn; bus.Flush_IN = flush;
    bus.Commit_IN = cm; bus.CommitArch_IN = 5'(c.arch);
    bus.CommitPhys_IN = 6'(c.phys); bus.CommitPrevPhys_IN = 6'(c.prev);
    eff = wd && (d != 0);
    freeCnt = flq.size() - spec;
    stallExp = stallIn | (v & eff & (freeCnt == 0));
    #1;
    check("stall_out", bus.Stall_OUT, stallExp);
    fire = v & !stallExp & !flush;
    if (fire) begin
      e.a = specMapM[a];
      e.b = specMapM[b];
      e.busy = eff;
      if (eff) begin
        e.p = flq[spec];
        e.d = flq[spec];
        e.p = specMapM[d];
        specMapM[d] = e.d;
        spec++;
        rob.push_back('{d, e.d, e.p});
      end else begin
        e.d = 0;
        e.p = 0;
      end
      sb.push_back(e);
    end
    if (cm) begin
      void'(rob.pop_front());
      retMapM[c.arch] = c.phys;
      void'(flq.pop_front());
      flq.push_back(c.prev);
      spec--;
    end
    if (flush) begin
      specMapM = retMapM;
      spec = 0;
      rob.delete();
    end
  endtask

  // Monitor: an output is consumed on an edge where Valid_OUT=1 and Stall_IN=0;
  // while held, SetBusy must only pulse on its first presentation.
  initial begin : monitor
    bit seen = 1'b0;
    expT e;
    forever begin
      @(negedge clk);
      if (monOn) begin
        if (bus.Valid_OUT) begin
          if (sb.size() == 0) begin
            check("unexpected_valid", bus.Valid_OUT, 0);
          end else begin
            e = sb[0];
            check("phys_src_a", bus.PhysSrcA_OUT, e.a);
            check("phys_src_b", bus.PhysSrcB_OUT, e.b);
            check("phys_dest", bus.PhysDest_OUT, e.d);
            check("prev_phys_dest", bus.PrevPhysDest_OUT, e.p);
            check("busy_reg", bus.BusyReg_OUT, e.d);
            check("set_busy", bus.SetBusy_OUT, e.busy && !seen);
            if (bus.SetBusy_OUT) check("busy_value", bus.BusyValue_OUT, 1);
            if (!bus.Stall_IN) begin
              void'(sb.pop_front());
              seen = 1'b0;
            end else begin
              seen = 1'b1;
            end
          end
        end else begin
          check("set_busy_idle", bus.SetBusy_OUT, 0);
        end
      end
    end
  end

  initial begin : driver
    int pct;
    bit st, fl;
    idleInputs();
    modelReset();
    doReset();
    @(negedge clk);
    check("reset_valid", bus.Valid_OUT, 0);
    check("reset_set_busy", bus.SetBusy_OUT, 0);
    check("reset_phys_dest", bus.PhysDest_OUT, 0);
    check("reset_prev_phys", bus.PrevPhysDest_OUT, 0);
    check("reset_busy_reg", bus.BusyReg_OUT, 0);
    check("reset_src_a", bus.PhysSrcA_OUT, 0);
    monOn = 1'b1;

    // First rename, back-to-back dependency, dest $0.
    cycle(1, 1, 2, 3, 1, 0, 0, 0);
    cycle(1, 3, 0, 3, 1, 0, 0, 0);
    cycle(1, 4, 5, 0, 1, 0, 0, 0);
    // Exhaust the free list, then free one slot via commit.
    for (int i = 0; i < 30; i++) cycle(1, i % 32, (i * 7) % 32, (i % 31) + 1, 1, 0, 0, 0);
    cycle(1, 1, 1, 7, 1, 0, 0, 0);
    cycle(1, 1, 1, 7, 1, 0, 0, 0);
    cycle(1, 1, 1, 7, 1, 0, 1, 0);
    cycle(1, 1, 1, 7, 1, 0, 0, 0);
    cycle(1, 2, 2, 0, 0, 0, 0, 0);

    // Flush discards speculative allocations.
    doReset();
    cycle(1, 0, 0, 1, 1, 0, 0, 0);
    cycle(1, 0, 0, 2, 1, 0, 0, 0);
    cycle(1, 0, 0, 3, 1, 0, 0, 0);
    cycle(1, 1, 2, 4, 1, 0, 0, 1);
    cycle(1, 5, 1, 5, 1, 0, 0, 0);

    // Downstream stall freezes outputs and allocation.
    cycle(1, 1, 2, 6, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) cycle(1, 6, 5, 8, 1, 1, 0, 0);
    cycle(1, 6, 5, 8, 1, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 0, 0);

    // Randomized traffic with varying commit pressure.
    for (int phase = 0; phase < 3; phase++) begin
      pct = (phase == 0) ? 10 : (phase == 1) ? 45 : 80;
      for (int n = 0; n < 1500; n++) begin
        if ($urandom_range(0, 299) == 0) begin
          doReset();
        end else begin
          st = ($urandom_range(0, 4) == 0);
          fl = !st && ($urandom_range(0, 39) == 0);
          cycle($urandom_range(0, 3) != 0, int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
                int'($urandom_range(0, 31)), $urandom_range(0, 4) != 0, st,
                $urandom_range(0, 99) < pct, fl);
        end
      end
    end

    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    check("scoreboard_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
